// File: rtl/if_fetch_ctrl_if.sv
// Fetch-side bus: instruction SRAM port plus the decode handshake.
// master = fetch controller, slave = memory/decode environment.
interface if_fetch_ctrl_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;
  logic        id_ready;

  modport master (
    output inst_req, inst_addr,
    output if_valid, if_pc, if_inst, if_adel,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  id_ready
  );

  modport slave (
    input  inst_req, inst_addr,
    input  if_valid, if_pc, if_inst, if_adel,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output id_ready
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding fetch, redirect hold/cancel,
// valid/ready hand-off to decode.
module if_fetch_ctrl #(
  parameter logic [31:0] PC_INITIAL = 32'hbfc00000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [31:0]            pc_reg,
  output logic                   pc_en,
  output logic                   pc_is_branch,
  output logic [31:0]            pc_branch_address,
  output logic                   pc_is_exception,
  output logic [31:0]            pc_exception_new_pc,
  input  logic                   br_valid,
  input  logic [31:0]            br_target,
  input  logic                   ex_valid,
  input  logic [31:0]            ex_target,
  if_fetch_ctrl_if.master        bus
);

  if (PC_INITIAL[1:0] != 2'b00) begin : g_bad_init
    $error("PC_INITIAL must be word aligned");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_n;
  logic        cancel;
  logic        pend_ex;
  logic [31:0] pend_target;
  logic [31:0] if_pc_q;
  logic [31:0] if_inst_q;
  logic        if_adel_q;

  logic        misal;
  logic        req;
  logic        accept;
  logic        data;
  logic        any_redir;
  logic        defer;
  logic        apply;
  logic        advance;
  logic        capture;
  logic        deliver;
  logic        sel_ex;
  logic [31:0] sel_target;

  assign misal   = pc_reg[1:0] != 2'b00;
  assign req     = resetn & (state == REQ) & ~misal;
  assign accept  = req & bus.inst_addr_ok;
  assign data    = (state == WAIT) & bus.inst_data_ok;

  // New ex > pending ex > new br > pending br.
  always_comb begin
    sel_ex     = ex_valid | (cancel & pend_ex);
    sel_target = pend_target;
    if (ex_valid)
      sel_target = ex_target;
    else if (!(cancel && pend_ex) && br_valid)
      sel_target = br_target;
  end

  assign any_redir = ex_valid | br_valid | cancel;
  assign defer     = any_redir
                   & (accept | ((state == WAIT) & ~bus.inst_data_ok));
  assign apply     = resetn & any_redir & ~defer;
  assign advance   = resetn & (state == HOLD) & bus.id_ready
                   & ~ex_valid & ~br_valid;
  assign capture   = (state == REQ) & misal & ~apply;
  assign deliver   = data & ~any_redir;

  assign pc_en               = apply | advance;
  assign pc_is_exception     = apply & sel_ex;
  assign pc_is_branch        = apply & ~sel_ex;
  assign pc_exception_new_pc = pc_is_exception ? sel_target : 32'h0;
  assign pc_branch_address   = pc_is_branch ? sel_target : 32'h0;

  assign bus.inst_req  = req;
  assign bus.inst_addr = pc_reg;
  assign bus.if_valid  = state == HOLD;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.if_adel   = if_adel_q;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (apply)       state_n = REQ;
        else if (accept) state_n = WAIT;
        else if (misal)  state_n = HOLD;
      end
      WAIT: begin
        if (apply)      state_n = REQ;
        else if (data)  state_n = HOLD;
      end
      HOLD: begin
        if (pc_en) state_n = REQ;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      cancel      <= 1'b0;
      pend_ex     <= 1'b0;
      pend_target <= 32'h0;
      if_pc_q     <= 32'h0;
      if_inst_q   <= 32'h0;
      if_adel_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (defer) begin
        cancel      <= 1'b1;
        pend_ex     <= sel_ex;
        pend_target <= sel_target;
      end else if (apply) begin
        cancel      <= 1'b0;
        pend_ex     <= 1'b0;
        pend_target <= 32'h0;
      end
      if (capture) begin
        if_pc_q   <= pc_reg;
        if_inst_q <= 32'h0;
        if_adel_q <= 1'b1;
      end else if (deliver) begin
        if_pc_q   <= pc_reg;
        if_inst_q <= bus.inst_rdata;
        if_adel_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Random bench for if_fetch_ctrl: PC register and SRAM models around the
// DUT, with a program-flow reference model of the expected fetch stream.
module tb_if_fetch_ctrl;
  localparam logic [31:0] INIT = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] pc_reg;
  logic        pc_en;
  logic        pc_is_branch;
  logic [31:0] pc_branch_address;
  logic        pc_is_exception;
  logic [31:0] pc_exception_new_pc;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_target = 32'h0;

  if_fetch_ctrl_if bus ();

  if_fetch_ctrl #(.PC_INITIAL(INIT)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .pc_reg              (pc_reg),
    .pc_en               (pc_en),
    .pc_is_branch        (pc_is_branch),
    .pc_branch_address   (pc_branch_address),
    .pc_is_exception     (pc_is_exception),
    .pc_exception_new_pc (pc_exception_new_pc),
    .br_valid            (br_valid),
    .br_target           (br_target),
    .ex_valid            (ex_valid),
    .ex_target           (ex_target),
    .bus                 (bus)
  );

  always #5 clk = ~clk;

  // PC register
  always_ff @(posedge clk) begin
    if (!resetn)
      pc_reg <= INIT;
    else if (pc_en)
      pc_reg <= pc_is_exception ? pc_exception_new_pc :
                pc_is_branch    ? pc_branch_address   : pc_reg + 32'd4;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] tgt();
    logic [31:0] t;
    t = {16'hbfc0, 6'h0, 8'($urandom), 2'b00};
    if ($urandom % 8 == 0) t[1:0] = 2'b10;
    return t;
  endfunction

  // reference model + memory-side state
  logic [31:0] m_pc = INIT;
  logic        armed = 1'b0;
  logic        armed_ex = 1'b0;
  logic [31:0] armed_tgt = 32'h0;
  logic        outst = 1'b0;
  int          lat = 0;
  logic [31:0] oaddr = 32'h0;
  logic        det = 1'b1;
  logic        prev_rst = 1'b0;
  logic        prev_v = 1'b0;
  logic        prev_en = 1'b0;
  logic        prev_deliver = 1'b0;
  int          stall = 0;

  always @(negedge clk) begin
    logic busy;
    logic exp_en;
    logic mis;
    logic deliver;
    if (!resetn) begin
      if (prev_rst) begin
        check("rst_req", 32'(bus.inst_req), 0);
        check("rst_pc_en", 32'(pc_en), 0);
        check("rst_is", 32'({pc_is_branch, pc_is_exception}), 0);
        check("rst_valid", 32'(bus.if_valid), 0);
        check("rst_if_pc", bus.if_pc, 0);
        check("rst_if_inst", bus.if_inst, 0);
        check("rst_adel", 32'(bus.if_adel), 0);
      end
      m_pc = INIT; armed = 0; outst = 0; lat = 0;
      prev_v = 0; prev_en = 0; prev_deliver = 0; stall = 0;
      prev_rst = 1;
    end else begin
      prev_rst = 0;
      mis = m_pc[1:0] != 2'b00;
      check("pc_reg", pc_reg, m_pc);
      if (bus.inst_req) begin
        check("req_addr", bus.inst_addr, m_pc);
        check("req_outst", 32'(outst), 0);
        check("req_in_hold", 32'(bus.if_valid), 0);
        check("req_align", 32'(mis), 0);
      end
      if (prev_deliver) check("valid_rise", 32'(bus.if_valid), 1);
      if (prev_v && !prev_en) check("valid_hold", 32'(bus.if_valid), 1);
      if (bus.if_valid) begin
        if (!prev_v) check("rise_src", 32'(prev_deliver || mis), 1);
        check("if_pc", bus.if_pc, m_pc);
        check("if_adel", 32'(bus.if_adel), 32'(mis));
        check("if_inst", bus.if_inst, mis ? 32'h0 : mem(m_pc));
      end
      if (ex_valid) begin
        armed = 1; armed_ex = 1; armed_tgt = ex_target;
      end else if (br_valid && !(armed && armed_ex)) begin
        armed = 1; armed_ex = 0; armed_tgt = br_target;
      end
      busy    = (outst && !bus.inst_data_ok) ||
                (bus.inst_req && bus.inst_addr_ok);
      exp_en  = (armed && !busy) || (bus.if_valid && bus.id_ready);
      deliver = outst && bus.inst_data_ok && !armed;
      check("pc_en", 32'(pc_en), 32'(exp_en));
      check("is_excl", 32'(pc_is_branch & pc_is_exception), 0);
      check("is_no_en", 32'((pc_is_branch | pc_is_exception) & !pc_en), 0);
      if (pc_en) begin
        if (armed) begin
          check("redir_ex", 32'(pc_is_exception), 32'(armed_ex));
          check("redir_br", 32'(pc_is_branch), 32'(!armed_ex));
          check("redir_tgt", armed_ex ? pc_exception_new_pc
                                      : pc_branch_address, armed_tgt);
          m_pc = armed_tgt;
          armed = 0;
        end else begin
          check("adv_is", 32'({pc_is_branch, pc_is_exception}), 0);
          m_pc = m_pc + 32'd4;
        end
        stall = 0;
      end else begin
        stall++;
        if (stall > 60) begin
          check("stall", 32'(stall), 0);
          stall = 0;
        end
      end
      if (outst && bus.inst_data_ok) outst = 0;
      else if (outst && lat > 0) lat--;
      if (bus.inst_req && bus.inst_addr_ok) begin
        outst = 1;
        oaddr = bus.inst_addr;
        lat   = det ? 0 : int'($urandom_range(0, 3));
      end
      prev_v = bus.if_valid;
      prev_en = pc_en;
      prev_deliver = deliver;
    end
  end

  task automatic quiet();
    bus.inst_addr_ok = 0;
    bus.inst_data_ok = 0;
    bus.inst_rdata   = 32'h0;
    bus.id_ready     = 0;
    br_valid = 0;
    ex_valid = 0;
  endtask

  task automatic drive();
    @(posedge clk); #1;
    bus.inst_addr_ok = det ? 1'b1 : ($urandom % 4 != 0);
    bus.id_ready     = det ? 1'b1 : ($urandom % 5 < 3);
    bus.inst_rdata   = $urandom;
    bus.inst_data_ok = 0;
    if (outst && lat == 0) begin
      bus.inst_data_ok = 1;
      bus.inst_rdata   = mem(oaddr);
    end else if (!det && !outst && $urandom % 12 == 0) begin
      bus.inst_data_ok = 1;
    end
    br_valid  = !det && ($urandom % 14 == 0);
    ex_valid  = !det && ($urandom % 20 == 0);
    br_target = tgt();
    ex_target = tgt();
  endtask

  initial begin
    quiet();
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    repeat (30) drive();
    det = 0;
    for (int r = 0; r < 4; r++) begin
      repeat (400) drive();
      for (int k = 0; k < 50 && !outst; k++) drive();
      check("rst_setup", 32'(outst), 1);
      @(posedge clk); #1;
      resetn = 0;
      quiet();
      repeat (2) @(posedge clk);
      #1 resetn = 1;
      bus.inst_data_ok = 1;
      bus.inst_rdata   = $urandom;
    end
    repeat (100) drive();
    quiet();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Instruction-fetch sequencer between the PC register and the instruction SRAM-like port (req/addr_ok/data_ok). It generates the PC register's pc_en and its redirect controls, issues one fetch at a time, and hands instructions to decode with a valid/ready handshake. It holds branch/exception redirects that arrive while a fetch is in flight, and it discards the stale response for such a fetch.

Parameters:
PC_INITIAL, 32'hbfc00000, reset fetch address; informational only, must match the PC register.

Ports:
clk  in  1  clock
resetn  in  1  reset
pc_reg  in  32  current PC from the PC register
pc_en  out  1  PC register update enable
pc_is_branch  out  1  to PC register is_branch
pc_branch_address  out  32  to PC register branch_address
pc_is_exception  out  1  to PC register is_exception
pc_exception_new_pc  out  32  to PC register exception_new_pc
inst_req  out  1  fetch request
inst_addr  out  32  fetch address (= pc_reg)
inst_addr_ok  in  1  request accepted
inst_data_ok  in  1  read data valid
inst_rdata  in  32  read data
if_valid  out  1  instruction valid to decode
if_pc  out  32  PC of presented instruction
if_inst  out  32  presented instruction
if_adel  out  1  presented slot is a misaligned-fetch exception (inst = 0)
id_ready  in  1  decode accepts
br_valid  in  1  branch redirect pulse
br_target  in  32  branch target
ex_valid  in  1  exception redirect pulse
ex_target  in  32  exception vector

Behaviour:
- Reset: resetn is synchronous and active-low; clock is clk. Reset state is IDLE; all outputs and internal registers are 0 (pending-redirect flag, pending targets, cancel flag).
- States:
  - IDLE: no request; goes to REQ in the next cycle.
  - REQ: inst_req=1 and inst_addr=pc_reg.
    - If inst_addr_ok=1, go to WAIT.
    - If pc_reg[1:0]!=0, inst_req stays 0 and the next state is HOLD, with if_adel=1, if_inst=0 and if_pc=pc_reg.
  - WAIT: inst_req=0.
    - On inst_data_ok with cancel=0: latch if_inst, if_pc and if_adel=0, then go to HOLD.
    - On inst_data_ok with cancel=1: drop the data, clear cancel, apply the pending redirect (see below), then go to REQ.
  - HOLD: if_valid=1 and the outputs are stable.
    - On id_ready=1 with no redirect this cycle: pc_en=1 for one cycle (PC advances +4), if_valid=0 next cycle, go to REQ.
- Redirect arbitration: when both arrive in the same cycle, ex beats br.
  - Redirect application: pc_en=1 with pc_is_exception/pc_exception_new_pc (or pc_is_branch/pc_branch_address) for exactly one cycle. if_valid is forced to 0 next cycle and the next state is REQ.
- Redirect timing: the redirect applies immediately in IDLE, in REQ without addr_ok, and in HOLD (the held instruction is dropped, even when id_ready=1 that cycle).
  - It is deferred in WAIT, or in REQ when addr_ok=1 the same cycle: the target is latched and cancel=1.
  - A later ex while one is pending overwrites the pending target. A later br does not overwrite a pending ex; it does overwrite a pending br.
- pc_is_* outputs are 0 whenever pc_en=0 and are never asserted without pc_en.
- Outstanding limit: at most one accepted request; inst_req is never asserted in WAIT.
- Latency: with addr_ok in cycle t and data_ok in t+k, if_valid rises at t+k+1. A handshake at cycle h yields the next inst_req at h+1.
- A data_ok outside WAIT is ignored.
- Reset mid-fetch returns to IDLE; a late data_ok is ignored because IDLE is not WAIT.

Test Plan:
- Reset then free-running fetch with addr_ok=1 and data_ok one cycle later, id_ready=1 → inst_addr sequence bfc00000, bfc00004, bfc00008; if_inst matches rdata; exactly one pc_en pulse per instruction.
- Decode stall: hold id_ready=0 for 5 cycles in HOLD → if_valid, if_pc and if_inst stay constant, pc_en=0, inst_req=0; release → one pc_en pulse, then the next fetch.
- Branch during WAIT: br_valid with br_target=bfc00100, data_ok 3 cycles later → data dropped, if_valid stays 0, pc_en+pc_is_branch pulse in the data_ok cycle, next inst_addr=bfc00100.
- Simultaneous ex_valid (ex_target=bfc00380) and br_valid in HOLD with id_ready=1 → held instruction dropped, pc_is_exception=1, pc_is_branch=0, next inst_addr=bfc00380.
- Misaligned target: redirect to bfc00102 → no inst_req; HOLD with if_adel=1, if_inst=0, if_pc=bfc00102.
- Reset asserted in WAIT, data_ok arrives after resetn rises → ignored; fetch restarts from pc_reg with if_valid=0 throughout.
